// File: rtl/booth_pkg.sv
// Shared state encoding and width helper for the sequential Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ADD   = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } booth_state_t;

    // Ceiling log2, used to size the iteration counter so it can hold N.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Operand/result bundle of the Booth multiplier: start/busy/done handshake.
interface booth_mult_seq_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/booth_ctrl.sv
// Booth control FSM: alternates ADD/SHIFT for WIDTH+1 iterations, fixed latency.
// start is honoured only in IDLE or DONE; requests while busy are dropped.
module booth_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic q0,
    input  logic q_1,
    output logic init,
    output logic add,
    output logic sub,
    output logic shift,
    output logic last,
    output logic done,
    output logic busy
);
    localparam int N  = WIDTH + 1;
    localparam int CW = clog2(N + 1);

    booth_state_t  state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        init      = 1'b0;
        add       = 1'b0;
        sub       = 1'b0;
        shift     = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    init      = 1'b1;
                    cnt_nxt   = CW'(N);
                    state_nxt = ADD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ADD: begin
                add       = ~q0 & q_1;
                sub       = q0 & ~q_1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                shift     = 1'b1;
                cnt_nxt   = cnt - CW'(1);
                last      = (cnt == CW'(1));
                state_nxt = last ? DONE : ADD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == ADD) || (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation; done 2*WIDTH+2 cycles after accept.
// One result per 2*WIDTH+3 cycles with start held; start while busy is ignored.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    booth_mult_seq_if.slave  bus
);
    localparam int N = WIDTH + 1;

    logic [N-1:0]       acc_q, mcand_q, mplier_q;
    logic               q_1;
    logic [2*WIDTH-1:0] product_q;

    logic init, add, sub, shift, last, done, busy;
    logic [N-1:0] ext_a, ext_b, add_res, acc_sh, mplier_sh;

    booth_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .start (bus.start),
        .q0    (mplier_q[0]),
        .q_1   (q_1),
        .init  (init),
        .add   (add),
        .sub   (sub),
        .shift (shift),
        .last  (last),
        .done  (done),
        .busy  (busy)
    );

    // One guard bit lets unsigned operands run through the signed Booth recoding.
    assign ext_a = {bus.signed_mode & bus.a[WIDTH-1], bus.a};
    assign ext_b = {bus.signed_mode & bus.b[WIDTH-1], bus.b};

    assign add_res   = sub ? (acc_q - mcand_q) : (acc_q + mcand_q);
    assign acc_sh    = {acc_q[N-1], acc_q[N-1:1]};
    assign mplier_sh = {acc_q[0], mplier_q[N-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            q_1       <= 1'b0;
            product_q <= '0;
        end else if (init) begin
            acc_q    <= '0;
            mplier_q <= ext_b;
            q_1      <= 1'b0;
            mcand_q  <= ext_a;
        end else if (add || sub) begin
            acc_q <= add_res;
        end else if (shift) begin
            acc_q    <= acc_sh;
            mplier_q <= mplier_sh;
            q_1      <= mplier_q[0];
            // Low 2*WIDTH bits of {A,Q} after the final shift are the exact product.
            if (last) product_q <= {acc_sh[WIDTH-2:0], mplier_sh};
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product_q;

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier: it integrates the datapath (accumulator, multiplier shift register, multiplicand register) with a generalised control FSM. It replaces the fixed 3-bit-window control unit with a WIDTH-generic design. It supports signed and unsigned operands selected per operation and uses a start/busy/done handshake. It sits between the operand registers and the result bus of the arithmetic unit.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled on clk, accepted only in IDLE or DONE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high while an operation is in progress (ADD/SHIFT states).
- done  out  1  one-cycle pulse, high in the DONE state.
- product  out  2*WIDTH  result; holds its value from DONE until the next accepted start.

## Operation
- Internal width: N = WIDTH+1. Operands are extended to N bits: sign-extended if signed_mode=1, zero-extended otherwise.
- Registers:
  - M (N bits) holds the extended a.
  - A (N bits) is the accumulator.
  - Q (N bits) holds the extended b.
  - q_1 (1 bit) is the Booth extra bit.
  - cnt counts down from N to 0; its width is clog2(N+1).
- FSM states: IDLE, ADD, SHIFT, DONE.
- Accept:
  - Condition: start=1 in IDLE or DONE.
  - Actions: A<=0, Q<=ext(b), q_1<=0, M<=ext(a), cnt<=N, next state ADD.
- ADD: the pair {Q[0], q_1} selects the operation.
  - 01: A<=A+M.
  - 10: A<=A-M.
  - 00 or 11: A holds.
  - In every case the state goes to SHIFT, so latency is fixed.
- SHIFT:
  - Arithmetic right shift of {A,Q,q_1} by one; the MSB of A is replicated.
  - cnt<=cnt-1.
  - If the new cnt is 0, go to DONE; otherwise go to ADD.
- DONE:
  - product<={A,Q}[2*WIDTH-1:0].
  - Without start, go to IDLE. With start, accept immediately (back-to-back operation).
- Arithmetic is modulo 2^N in A. The true product always fits in 2*WIDTH bits for both modes, so the truncation to 2*WIDTH bits is exact.
- start while busy=1 is ignored. Operand inputs are not resampled.
- rst=1 at any clock, including mid-operation:
  - state<=IDLE.
  - A, Q, q_1, M, cnt<=0.
  - product<=0.
  - busy and done go low at that edge.

## Timing
- Reset values: busy=0, done=0, product=0.
- Accepting edge E0: busy=1 from E0 onward.
- The operation alternates ADD/SHIFT for N iterations, which takes 2N cycles.
- DONE is entered at edge E0+2N: done=1 and product is valid in the same cycle, and busy=0 from that edge.
- Latency from the accepting edge to done is 2*WIDTH+2 cycles; for WIDTH=8 this is 18.
- Back-to-back operation: start=1 during DONE gives a new accept at the end of the DONE cycle. Throughput is one result per 2N+1 cycles.
- product is registered and changes only at entry to DONE or on rst.

## Structure
- Shared package booth_pkg:
  - state encoding constants (IDLE=2'b00, ADD=2'b01, SHIFT=2'b10, DONE=2'b11);
  - a clog2 function for the cnt width.
- Sub-module booth_ctrl:
  - FSM and counter;
  - inputs: clk, rst, start, q0, q_1;
  - outputs: init, add, sub, shift, done, busy.
- The top level holds the datapath registers and the N-bit adder/subtractor.

## Test plan
- WIDTH=8, signed: a=3, b=-4 (0xFC) -> product=0xFFF4, done pulse exactly 18 cycles after the accepting edge.
- WIDTH=8:
  - unsigned 255*255 -> 0xFE01;
  - signed -128*-128 -> 0x4000;
  - signed -128*127 -> 0xC080.
- Start pulses during busy -> ignored. The first result is unchanged, and done asserts only once.
- Assert rst at cycle 7 of an operation -> busy=0, done=0, product=0 next cycle. A new start then completes with the correct result.
- start held high through DONE -> the second operation is accepted with no IDLE cycle. The first product is visible during DONE, and the second arrives 2N+1 cycles later.
- WIDTH=16 random signed/unsigned sweep (1000 ops) against a reference model -> all products match, latency is 34 cycles.
